// File: rtl/pulse_monitor.sv
// Pulse monitor: measures high-pulse lengths on in, counts completed pulses, one-entry result buffer.
// Latency: valid rises 2 edges after in falls; +2 edges with PULSE_MONITOR_SYNC_EN (2-flop input synchronizer).
// Backpressure: valid/ready; a pulse completing while the buffer is full and not drained is dropped and sets sticky overflow.
module pulse_monitor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] pulse_len,
    output logic             sat,
    output logic [WIDTH-1:0] pulse_cnt,
    output logic             overflow
);
    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state;
    logic             in_s;
    logic             in_q;
    logic             prev;
    logic [WIDTH-1:0] count;
    logic             done;

`ifdef PULSE_MONITOR_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    assign in_s = sync2;
`else
    assign in_s = in;
`endif

    assign done = (state == MEASURE) && !in_q;

    // in_q/prev reset high so a line already high at reset release is not seen as a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q      <= 1'b1;
            prev      <= 1'b1;
            state     <= IDLE;
            count     <= '0;
            valid     <= 1'b0;
            pulse_len <= '0;
            sat       <= 1'b0;
            pulse_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            in_q <= in_s;
            prev <= in_q;

            case (state)
                IDLE: begin
                    if (!prev && in_q) begin
                        state <= MEASURE;
                        count <= {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                MEASURE: begin
                    if (in_q) begin
                        if (count != MAX) begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        state     <= IDLE;
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A same-edge accept and completion reloads the buffer without a bubble.
            if (done) begin
                if (!valid || ready) begin
                    valid     <= 1'b1;
                    pulse_len <= count;
                    sat       <= (count == MAX);
                end else begin
                    overflow <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_monitor.sv
// Bench for pulse_monitor (WIDTH=8): directed vector table, hand-written corner sequences, random run vs sample-history model.
module tb_pulse_monitor;
    logic       clk;
    logic       reset;
    logic       in_l;
    logic       ready;
    logic       valid;
    logic [7:0] pulse_len;
    logic       sat;
    logic [7:0] pulse_cnt;
    logic       overflow;

`ifdef PULSE_MONITOR_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    pulse_monitor #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_l),
        .ready     (ready),
        .valid     (valid),
        .pulse_len (pulse_len),
        .sat       (sat),
        .pulse_cnt (pulse_cnt),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: history of the line as seen by the measuring logic.
    bit         hist[$];
    logic       d1, d2;
    logic       m_valid, m_sat, m_ovf;
    logic [7:0] m_len, m_cnt;

    typedef struct {
        logic       lvl;
        logic       rdy;
        int         n;
        bit         chk;
        logic       e_valid;
        logic [7:0] e_len;
        logic       e_sat;
        logic [7:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        d1 = 1'b1;
        d2 = 1'b1;
        m_valid = 1'b0;
        m_sat = 1'b0;
        m_ovf = 1'b0;
        m_len = '0;
        m_cnt = '0;
    endtask

    task automatic model_edge(input logic i, input logic r);
        logic smp;
        bit   comp;
        bit   armed;
        int   n;
`ifdef PULSE_MONITOR_SYNC_EN
        smp = d2;
        d2 = d1;
        d1 = i;
`else
        smp = i;
`endif
        comp = 0;
        n = 0;
        // A pulse completes one edge after the first low sample that ends a run of highs,
        // provided that run was preceded by a low sample (i.e. it started after reset).
        if (hist.size() >= 2 && hist[hist.size()-1] == 1'b0 && hist[hist.size()-2] == 1'b1) begin
            armed = 0;
            for (int k = hist.size() - 2; k >= 0; k--) begin
                if (hist[k]) n++;
                else begin
                    armed = 1;
                    break;
                end
            end
            comp = armed;
        end
        hist.push_back(smp);
        if (comp) begin
            m_cnt = m_cnt + 8'd1;
            if (!m_valid || r) begin
                m_valid = 1'b1;
                m_len = (n > 255) ? 8'd255 : n[7:0];
                m_sat = (n >= 255);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic i, input logic r);
        in_l = i;
        ready = r;
        @(posedge clk);
        model_edge(i, r);
        @(negedge clk);
        chk("model valid", valid, m_valid);
        chk("model pulse_cnt", pulse_cnt, m_cnt);
        chk("model overflow", overflow, m_ovf);
        if (m_valid) begin
            chk("model pulse_len", pulse_len, m_len);
            chk("model sat", sat, m_sat);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " valid"}, valid, 0);
        chk({nm, " pulse_len"}, pulse_len, 0);
        chk({nm, " sat"}, sat, 0);
        chk({nm, " pulse_cnt"}, pulse_cnt, 0);
        chk({nm, " overflow"}, overflow, 0);
    endtask

    task automatic do_reset(input logic lvl);
        in_l = lvl;
        ready = 1'b1;
        reset = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
    endtask

    int first;

    initial begin
        in_l = 1'b0;
        ready = 1'b1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);

        // Directed vector table: constant expectations checked at the end of marked segments.
        vecs.push_back('{1'b0, 1'b1, 5,   1, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 10,  1, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 6,   1, 1'b1, 8'd10,  1'b0, 8'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3,   1, 1'b1, 8'd10,  1'b0, 8'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 6,   1, 1'b1, 8'd10,  1'b0, 8'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1,   1, 1'b0, 8'd0,   1'b0, 8'd2, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 300, 1, 1'b0, 8'd0,   1'b0, 8'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 6,   1, 1'b1, 8'd255, 1'b1, 8'd3, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1,   1, 1'b0, 8'd0,   1'b0, 8'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3,   0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2,   0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5,   0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2,   0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 7,   0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 6,   1, 1'b1, 8'd3,   1'b0, 8'd6, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1,   1, 1'b0, 8'd0,   1'b0, 8'd6, 1'b1});

        do_reset(1'b0);
        for (int v = 0; v < vecs.size(); v++) begin
            for (int c = 0; c < vecs[v].n; c++) step(vecs[v].lvl, vecs[v].rdy);
            if (vecs[v].chk) begin
                chk($sformatf("vec%0d valid", v), valid, vecs[v].e_valid);
                chk($sformatf("vec%0d pulse_cnt", v), pulse_cnt, vecs[v].e_cnt);
                chk($sformatf("vec%0d overflow", v), overflow, vecs[v].e_ovf);
                if (vecs[v].e_valid) begin
                    chk($sformatf("vec%0d pulse_len", v), pulse_len, vecs[v].e_len);
                    chk($sformatf("vec%0d sat", v), sat, vecs[v].e_sat);
                end
            end
        end

        // 10-cycle pulse: latency from fall to valid, then a one-cycle valid.
        do_reset(1'b0);
        repeat (5) step(1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b1);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1);
            if (valid) begin
                first = k;
                break;
            end
        end
        chk("latency edges", first, LAT);
        chk("len10 pulse_len", pulse_len, 10);
        chk("len10 sat", sat, 0);
        chk("len10 pulse_cnt", pulse_cnt, 1);
        step(1'b0, 1'b1);
        chk("len10 valid drop", valid, 0);

        // Completion on the same edge the held result is accepted.
        do_reset(1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        repeat (LAT + 2) step(1'b0, 1'b0);
        chk("hold pulse_len", pulse_len, 4);
        repeat (6) step(1'b1, 1'b0);
        repeat (LAT - 1) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("swap valid", valid, 1);
        chk("swap pulse_len", pulse_len, 6);
        chk("swap overflow", overflow, 0);

        // Line high through reset release, then low, then a 4-cycle pulse.
        do_reset(1'b1);
        repeat (5) step(1'b1, 1'b1);
        chk("high-at-reset valid", valid, 0);
        chk("high-at-reset pulse_cnt", pulse_cnt, 0);
        repeat (3) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        repeat (LAT + 3) step(1'b0, 1'b0);
        chk("post-reset valid", valid, 1);
        chk("post-reset pulse_len", pulse_len, 4);
        chk("post-reset pulse_cnt", pulse_cnt, 1);

        // Reset mid-pulse clears outputs without a clock edge.
        repeat (3) step(1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async");
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Random runs with random ready, one mid-run reset with the line high.
        for (int s = 0; s < 200; s++) begin
            int n;
            logic lvl;
            lvl = logic'(s % 2);
            n = ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(1, 6));
            for (int c = 0; c < n; c++) step(lvl, $urandom_range(0, 2) != 0);
            if (s == 101) begin
                do_reset(1'b1);
                repeat (2) step(1'b1, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 Parameter WIDTH, default 8: width of the pulse-length and pulse-count fields.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in  input  1  observed line carrying high pulses.
REQ-005 ready  input  1  consumer accepts the held result in a cycle where valid=1.
REQ-006 valid  output  1  result buffer holds an unconsumed pulse measurement.
REQ-007 pulse_len  output  WIDTH  length of the buffered pulse in clk cycles; meaningful only while valid=1.
REQ-008 sat  output  1  buffered pulse was at least 2^WIDTH-1 cycles long and pulse_len is saturated.
REQ-009 pulse_cnt  output  WIDTH  number of completed pulses since reset, including dropped ones.
REQ-010 overflow  output  1  sticky flag: at least one completed pulse was dropped because the buffer was full.

Function
REQ-011 The block SHALL register in into an internal sample in_q on every clk edge; edge detection SHALL compare in_q with its previous value prev.
REQ-012 FSM states SHALL be IDLE and MEASURE, with reset state IDLE.
REQ-013 IDLE->MEASURE SHALL occur on a rise (prev=0, in_q=1), with the counter loaded to 1.
REQ-014 In MEASURE with in_q=1, the counter SHALL increment by 1 per cycle and saturate at 2^WIDTH-1 without wrapping.
REQ-015 In MEASURE with in_q=0 (fall), the pulse SHALL complete, the FSM SHALL return to IDLE, and pulse_cnt SHALL increment modulo 2^WIDTH.
REQ-016 A pulse that is high on N consecutive sampling edges SHALL report pulse_len=N, with sat=1 iff N>=2^WIDTH-1.
REQ-017 Latency: valid SHALL rise on the clk edge after the first edge that samples in=0, i.e. 2 edges after in falls.
REQ-018 A completed pulse SHALL load the buffer (pulse_len, sat, valid=1) if valid=0, or if valid=1 and ready=1 in the same cycle.
REQ-019 A simultaneous accept and completion SHALL keep valid=1 and carry the new values, with no bubble.
REQ-020 Valid=1, ready=0 at completion SHALL drop the new pulse, leave the buffer unchanged, and set overflow=1 until reset.
REQ-021 Valid=1, ready=1 with no completion SHALL clear valid on that edge.
REQ-022 pulse_len and sat SHALL remain stable while valid=1 and ready=0.
REQ-023 A line already high when reset deasserts SHALL NOT be counted as a pulse; measurement SHALL begin only after a low sample followed by a rise.
REQ-024 A one-cycle low gap between pulses SHALL be sufficient for both pulses to be measured separately.

Reset
REQ-025 Reset SHALL force valid=0, pulse_len=0, sat=0, pulse_cnt=0, overflow=0, state IDLE, counter 0, and in_q=prev=1.
REQ-026 Reset asserted mid-pulse SHALL discard the partial measurement immediately, without waiting for clk.
REQ-027 No output SHALL change on the first clk edge after reset deasserts.

Configuration
REQ-028 Macro PULSE_MONITOR_SYNC_EN, when defined, SHALL insert a two-flop synchronizer (reset value 1) ahead of in_q.
REQ-029 With PULSE_MONITOR_SYNC_EN defined, REQ-017 latency SHALL grow by exactly 2 clk edges and measured lengths SHALL be unchanged.
REQ-030 Without PULSE_MONITOR_SYNC_EN, in SHALL feed in_q directly, and the block SHALL be used only with in synchronous to clk.

Verification (clk period 10 ns, WIDTH=8, ready=1 unless stated)
REQ-031 Reset 100 ns, in low, then in high for 10 clk cycles and low -> valid pulses 1 cycle with pulse_len=10, sat=0, pulse_cnt=1.
REQ-032 in high for 300 cycles -> pulse_len=255, sat=1, pulse_cnt=1.
REQ-033 ready=0, three pulses of lengths 3, 5, 7 -> buffer holds 3, overflow=1, pulse_cnt=3; then ready=1 -> valid drops after one cycle.
REQ-034 Pulse completes in the same cycle the held result is accepted -> valid stays 1 and pulse_len changes to the new length, with overflow=0.
REQ-035 in held high through reset release, then low, then 4-cycle pulse -> exactly one result with pulse_len=4; reset asserted mid-pulse -> all outputs 0 asynchronously.
REQ-036 With PULSE_MONITOR_SYNC_EN defined, repeat REQ-031 -> same pulse_len=10, with valid rising 2 edges later.
